// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_pkg
//  Description : Screen geometry shared by the video path blocks.
//  Revision    : 1.0
// ============================================================================
package video_pkg;

   localparam int H_ATTIVO = 1280;
   localparam int V_ATTIVO = 1024;
   localparam int COORD_W  = 11;

endpackage
`default_nettype wire

// File: rtl/distanza_toroidale.sv
`default_nettype none
// ============================================================================
//  Module      : distanza_toroidale
//  Description : Shortest distance between two coordinates on a ring of size m_i.
//  Revision    : 1.0
// ============================================================================
module distanza_toroidale #(
   parameter int W = 11
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] m_i,
   output logic [W-1:0] d_o
);

   logic [W-1:0] diff;
   logic [W-1:0] wrap;

   // Result is meaningful only when both coordinates lie below m_i.
   always_comb begin
      diff = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
      wrap = m_i - diff;
      d_o  = (wrap < diff) ? wrap : diff;
   end

endmodule
`default_nettype wire

// File: rtl/rettangolo_mobile.sv
`default_nettype none
// ============================================================================
//  Module      : rettangolo_mobile
//  Description : Movable rectangle/frame with a 2-stage pixel membership pipeline.
//  Revision    : 1.0
// ============================================================================
module rettangolo_mobile
   import video_pkg::*;
#(
   parameter int ALTEZZA   = 100,
   parameter int LARGHEZZA = 100,
   parameter int SPESSORE  = 6,
   parameter int PASSO     = 4,
   parameter int X_INIZ    = 640,
   parameter int Y_INIZ    = 512,
   parameter int H         = H_ATTIVO,
   parameter int V         = V_ATTIVO
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               FRAME_TICK,
   input  logic               CMD_SX,
   input  logic               CMD_DX,
   input  logic               CMD_SU,
   input  logic               CMD_GIU,
   input  logic               MODO,
   input  logic [COORD_W-1:0] X_CONTROLLO,
   input  logic [COORD_W-1:0] Y_CONTROLLO,
   output logic [COORD_W-1:0] X_POS,
   output logic [COORD_W-1:0] Y_POS,
   output logic               CONFERMA,
   output logic               ESTERNO,
   output logic               INTERNO
);

   localparam int EW = COORD_W + 1;

   localparam logic [EW-1:0]      c_passo_e = EW'(PASSO);
   localparam logic [EW-1:0]      c_h_e     = EW'(H);
   localparam logic [EW-1:0]      c_y_min_e = EW'(ALTEZZA / 2);
   localparam logic [EW-1:0]      c_y_max_e = EW'(V - 1 - ALTEZZA / 2);
   localparam logic [COORD_W-1:0] c_h       = COORD_W'(H);
   localparam logic [COORD_W-1:0] c_v       = COORD_W'(V);
   localparam logic [COORD_W-1:0] c_half_l  = COORD_W'(LARGHEZZA / 2);
   localparam logic [COORD_W-1:0] c_half_a  = COORD_W'(ALTEZZA / 2);
   localparam logic [COORD_W-1:0] c_inner_l = COORD_W'(LARGHEZZA / 2 - SPESSORE);
   localparam logic [COORD_W-1:0] c_inner_a = COORD_W'(ALTEZZA / 2 - SPESSORE);
   localparam logic [COORD_W-1:0] c_x_iniz  = COORD_W'(X_INIZ);
   localparam logic [COORD_W-1:0] c_y_iniz  = COORD_W'(Y_INIZ);

   logic [COORD_W-1:0] x_pos_q, x_pos_d;
   logic [COORD_W-1:0] y_pos_q, y_pos_d;
   logic [EW-1:0]      x_e, y_e;

   // One extra bit keeps the wrap and clamp arithmetic free of underflow.
   always_comb begin
      x_e     = {1'b0, x_pos_q};
      y_e     = {1'b0, y_pos_q};
      x_pos_d = x_pos_q;
      y_pos_d = y_pos_q;
      if (FRAME_TICK) begin
         if (CMD_SX && !CMD_DX)
            x_pos_d = COORD_W'((x_e >= c_passo_e) ? (x_e - c_passo_e) : (x_e + c_h_e - c_passo_e));
         else if (CMD_DX && !CMD_SX)
            x_pos_d = COORD_W'((x_e + c_passo_e >= c_h_e) ? (x_e + c_passo_e - c_h_e) : (x_e + c_passo_e));
         if (CMD_SU && !CMD_GIU)
            y_pos_d = COORD_W'((y_e >= c_y_min_e + c_passo_e) ? (y_e - c_passo_e) : c_y_min_e);
         else if (CMD_GIU && !CMD_SU)
            y_pos_d = COORD_W'((y_e + c_passo_e > c_y_max_e) ? c_y_max_e : (y_e + c_passo_e));
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         x_pos_q <= c_x_iniz;
         y_pos_q <= c_y_iniz;
      end else begin
         x_pos_q <= x_pos_d;
         y_pos_q <= y_pos_d;
      end
   end

   logic [COORD_W-1:0] dx_d, dy_d;
   logic               valid_d;

   distanza_toroidale #(
      .W (COORD_W)
   ) u_dist_x (
      .a_i (X_CONTROLLO),
      .b_i (x_pos_q),
      .m_i (c_h),
      .d_o (dx_d)
   );

   always_comb begin
      dy_d    = (Y_CONTROLLO >= y_pos_q) ? (Y_CONTROLLO - y_pos_q) : (y_pos_q - Y_CONTROLLO);
      valid_d = (X_CONTROLLO < c_h) && (Y_CONTROLLO < c_v);
   end

   logic [COORD_W-1:0] dx_q, dy_q;
   logic               modo_q, valid_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         dx_q    <= '0;
         dy_q    <= '0;
         modo_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         modo_q  <= MODO;
         valid_q <= valid_d;
      end
   end

   logic esterno_d, interno_d, conferma_d;
   logic esterno_q, interno_q, conferma_q;

   // Blanking samples carry valid_q=0, which forces all three flags low.
   always_comb begin
      esterno_d  = valid_q && (dx_q < c_half_l) && (dy_q < c_half_a);
      interno_d  = valid_q && (dx_q < c_inner_l) && (dy_q < c_inner_a);
      conferma_d = modo_q ? (esterno_d && !interno_d) : esterno_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         esterno_q  <= 1'b0;
         interno_q  <= 1'b0;
         conferma_q <= 1'b0;
      end else begin
         esterno_q  <= esterno_d;
         interno_q  <= interno_d;
         conferma_q <= conferma_d;
      end
   end

   assign X_POS    = x_pos_q;
   assign Y_POS    = y_pos_q;
   assign ESTERNO  = esterno_q;
   assign INTERNO  = interno_q;
   assign CONFERMA = conferma_q;

endmodule
`default_nettype wire

// File: tb/tb_rettangolo_mobile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rettangolo_mobile
//  Description : Self-checking bench for rettangolo_mobile (two parameterisations).
//  Revision    : 1.0
// ============================================================================
module tb_rettangolo_mobile;

   localparam int H = 1280;
   localparam int V = 1024;
   localparam int A = 100;
   localparam int L = 100;
   localparam int S = 6;
   localparam int P = 4;

   logic        clk = 1'b0;
   logic        rst, ft, sx, dx, su, giu, modo;
   logic [10:0] xc, yc;
   logic [10:0] a_x, a_y, b_x, b_y;
   logic        a_c, a_e, a_i, b_c, b_e, b_i;

   always #5 clk = ~clk;

   rettangolo_mobile u_a (
      .CLK (clk), .RST (rst), .FRAME_TICK (ft),
      .CMD_SX (sx), .CMD_DX (dx), .CMD_SU (su), .CMD_GIU (giu), .MODO (modo),
      .X_CONTROLLO (xc), .Y_CONTROLLO (yc),
      .X_POS (a_x), .Y_POS (a_y), .CONFERMA (a_c), .ESTERNO (a_e), .INTERNO (a_i)
   );

   rettangolo_mobile #(.X_INIZ (1278), .Y_INIZ (52)) u_b (
      .CLK (clk), .RST (rst), .FRAME_TICK (ft),
      .CMD_SX (sx), .CMD_DX (dx), .CMD_SU (su), .CMD_GIU (giu), .MODO (modo),
      .X_CONTROLLO (xc), .Y_CONTROLLO (yc),
      .X_POS (b_x), .Y_POS (b_y), .CONFERMA (b_c), .ESTERNO (b_e), .INTERNO (b_i)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   int          xi[2];
   int          yi[2];
   int          mx[2];
   int          my[2];
   logic [2:0]  st1[2];
   logic [2:0]  st2[2];

   typedef struct {
      int   inst;
      logic modo;
      int   xc;
      int   yc;
      logic c;
      logic e;
      logic i;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference answer {conferma, esterno, interno} for a pixel against a centre.
   function automatic logic [2:0] pix(input int cx, input int cy, input int px, input int py,
                                      input logic m);
      int   ddx;
      int   ddy;
      logic e;
      logic i;
      if (px >= H || py >= V) return 3'b000;
      ddx = (px > cx) ? px - cx : cx - px;
      if (H - ddx < ddx) ddx = H - ddx;
      ddy = (py > cy) ? py - cy : cy - py;
      e = (ddx < L / 2) && (ddy < A / 2);
      i = (ddx < L / 2 - S) && (ddy < A / 2 - S);
      return {(m ? (e && !i) : e), e, i};
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then check both DUTs.
   task automatic cyc();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            mx[k]  = xi[k];
            my[k]  = yi[k];
            st1[k] = 3'b000;
            st2[k] = 3'b000;
         end else begin
            st2[k] = st1[k];
            st1[k] = pix(mx[k], my[k], int'(xc), int'(yc), modo);
            if (ft) begin
               if (sx && !dx)      mx[k] = (mx[k] + H - P) % H;
               else if (dx && !sx) mx[k] = (mx[k] + P) % H;
               if (su && !giu)      my[k] = (my[k] - P < A / 2) ? A / 2 : my[k] - P;
               else if (giu && !su) my[k] = (my[k] + P > V - 1 - A / 2) ? V - 1 - A / 2 : my[k] + P;
            end
         end
      end
      #1;
      chk("a_xpos", a_x, mx[0]);
      chk("a_ypos", a_y, my[0]);
      chk("a_flags", {a_c, a_e, a_i}, st2[0]);
      chk("b_xpos", b_x, mx[1]);
      chk("b_ypos", b_y, my[1]);
      chk("b_flags", {b_c, b_e, b_i}, st2[1]);
   endtask

   // Back-to-back vectors; each result is checked two edges after it was applied.
   task automatic run_vec(input int lo, input int hi);
      logic [2:0] got;
      for (int j = lo; j <= hi + 1; j++) begin
         if (j <= hi) begin
            xc   = 11'(tbl[j].xc);
            yc   = 11'(tbl[j].yc);
            modo = tbl[j].modo;
         end else begin
            xc = 11'd2047;
            yc = 11'd0;
         end
         cyc();
         if (j > lo) begin
            got = (tbl[j-1].inst == 0) ? {a_c, a_e, a_i} : {b_c, b_e, b_i};
            chk($sformatf("vec%0d_cei", j - 1), got, {tbl[j-1].c, tbl[j-1].e, tbl[j-1].i});
         end
      end
   endtask

   task automatic set_cmd(input logic t, input logic l, input logic r, input logic u, input logic d);
      ft  = t;
      sx  = l;
      dx  = r;
      su  = u;
      giu = d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int r;
      xi[0] = 640;  yi[0] = 512;
      xi[1] = 1278; yi[1] = 52;

      // inst 1 centred at (10,512) for the wrap cases, inst 0 at (640,512) for the rest
      tbl[0]  = '{1, 1'b0, 1250, 512, 1'b1, 1'b1, 1'b1};
      tbl[1]  = '{1, 1'b0, 1200, 512, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1, 1'b0,   59, 512, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1, 1'b0,   60, 512, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1, 1'b0,   10, 461, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1, 1'b0,   10, 463, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1, 1'b0, 1280, 512, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{0, 1'b1,  592, 512, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{0, 1'b1,  640, 512, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{0, 1'b0,  640, 512, 1'b1, 1'b1, 1'b1};
      tbl[10] = '{0, 1'b1,  640, 467, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{0, 1'b0,  640, 1024, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{0, 1'b0, 1280, 512, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{0, 1'b1,  690, 512, 1'b0, 1'b0, 1'b0};

      set_cmd(0, 0, 0, 0, 0);
      modo = 1'b0;
      xc   = 11'd0;
      yc   = 11'd0;
      rst  = 1'b1;
      cyc();
      chk("rst_a_x", a_x, 640);
      chk("rst_a_y", a_y, 512);
      chk("rst_a_conf", a_c, 0);
      chk("rst_b_x", b_x, 1278);
      chk("rst_b_y", b_y, 52);
      rst = 1'b0;

      set_cmd(1, 0, 1, 0, 0); cyc(); chk("wrap_right", b_x, 2);
      set_cmd(1, 1, 0, 0, 0); cyc(); chk("wrap_left", b_x, 1278);
      set_cmd(1, 0, 0, 1, 0); cyc(); chk("clamp_up1", b_y, 50);
      cyc();                         chk("clamp_up2", b_y, 50);
      set_cmd(1, 0, 0, 1, 1); cyc(); chk("both_vert", b_y, 50);
      set_cmd(0, 0, 1, 0, 0); cyc(); chk("no_tick", b_x, 1278);

      rst = 1'b1; set_cmd(0, 0, 0, 0, 0); cyc(); rst = 1'b0;
      set_cmd(1, 0, 1, 0, 1);
      repeat (3) cyc();
      set_cmd(1, 0, 0, 0, 1);
      repeat (112) cyc();
      set_cmd(0, 0, 0, 0, 0);
      chk("b_at_x10", b_x, 10);
      chk("b_at_y512", b_y, 512);
      run_vec(0, 6);

      rst = 1'b1; cyc(); rst = 1'b0;
      run_vec(7, 13);

      modo = 1'b0; xc = 11'd689; yc = 11'd512;
      set_cmd(1, 0, 1, 0, 0); cyc(); set_cmd(0, 0, 0, 0, 0);
      chk("tick_x644", a_x, 644);
      cyc();                    chk("same_cycle_oldx", a_c, 1);
      xc = 11'd692; cyc();      chk("next_cycle_newx", a_c, 1);
      set_cmd(1, 1, 0, 0, 0); cyc(); set_cmd(0, 0, 0, 0, 0);
      chk("x692_at644", a_c, 1);
      cyc();                    chk("x692_back640", a_x, 640);
      xc = 11'd2047; cyc();     chk("x692_at640", a_c, 0);

      xc = 11'd640; yc = 11'd512;
      cyc(); cyc();             chk("pipe_full", a_c, 1);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("flush_conf", a_c, 0);
      chk("flush_est", a_e, 0);
      chk("flush_int", a_i, 0);
      cyc();                    chk("flush_stage1", a_c, 0);
      cyc();                    chk("refill", a_c, 1);

      for (int n = 0; n < 3000; n++) begin
         rst  = ($urandom_range(0, 299) == 0);
         ft   = ($urandom_range(0, 3) == 0);
         {sx, dx, su, giu} = 4'($urandom);
         modo = 1'($urandom);
         r    = int'($urandom_range(0, 120)) - 60;
         case ($urandom_range(0, 3))
            0: begin xc = 11'($urandom); yc = 11'($urandom); end
            1: begin xc = 11'((mx[0] + H + r) % H); yc = 11'(my[0] + int'($urandom_range(0, 120)) - 60); end
            2: begin xc = 11'((mx[1] + H + r) % H); yc = 11'(my[1] + int'($urandom_range(0, 120)) - 60); end
            default: begin xc = 11'($urandom_range(0, 1) != 0 ? (H - 1 - $urandom_range(0, 60)) : $urandom_range(0, 60));
                           yc = 11'($urandom_range(0, V + 20)); end
         endcase
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
